// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared constants and helpers for the K=7, rate-1/2 convolutional code
// (g1 = 171 octal on symbol bit 1, g0 = 133 octal on symbol bit 0) and its
// 64-state hard-decision Viterbi decoder.
//   K        constraint length
//   NSTATES  trellis states (2^(K-1))
//   D        register-exchange survivor depth
//   MW       path-metric width (modular arithmetic)
//   G1, G0   generator polynomials, bit 6 taps the newest input bit
package viterbi_pkg;

  localparam int K       = 7;
  localparam int NSTATES = 64;
  localparam int D       = 48;
  localparam int MW      = 8;

  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G0 = 7'o133;

  // Start-up metric for every state except 0; a clean start means the
  // encoder is known to begin in state 0.
  localparam logic [MW-1:0] PM_INIT = 8'd64;

  function automatic logic parity7(input logic [K-1:0] v);
    return ^v;
  endfunction

  // Code symbol {c1,c0} emitted when input bit u enters an encoder whose
  // shift register holds st (newest previous bit in st[5]).
  function automatic logic [1:0] exp_sym(input logic [K-2:0] st, input logic u);
    return {parity7(G1 & {u, st}), parity7(G0 & {u, st})};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/encoder.sv
// encoder
// Convolutional encoder matching viterbi_decoder. Outputs are registered.
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   enable_i  high = d_in is an information bit to encode this cycle
//   d_in      information bit
//   valid_o   high for one cycle per encoded bit, aligned with d_out
//   d_out     code symbol {c1,c0}; 00 when valid_o is low
// Handshake: enable_i/valid_o are qualifiers only; there is no back-pressure,
// every enabled input produces exactly one valid symbol on the next cycle.
module encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  logic [K-2:0] r_s;
  logic         r_valid;
  logic [1:0]   r_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s     <= '0;
      r_valid <= 1'b0;
      r_dout  <= 2'b00;
    end else if (enable_i) begin
      r_dout  <= exp_sym(r_s, d_in);
      r_valid <= 1'b1;
      r_s     <= {d_in, r_s[K-2:1]};
    end else begin
      r_valid <= 1'b0;
      r_dout  <= 2'b00;
    end
  end

  assign valid_o = r_valid;
  assign d_out   = r_dout;

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder
// Hard-decision Viterbi decoder for the K=7 rate-1/2 code, register-exchange
// survivors of depth D, decoded bits read from the oldest survivor bit of
// state 0 (fixed decision state, no traceback).
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   enable  high = d_in carries a valid code symbol this cycle
//   d_in    received symbol {c1,c0}
//   d_out   registered decoded bit; after the n-th enabled edge it holds
//           decoded bit n-47 (0 before the pipeline fills)
// Handshake: enable is a pure qualifier with no back-pressure; when low, all
// state (metrics, survivors, d_out) holds.
module viterbi_decoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  logic [MW-1:0] r_pm       [NSTATES];
  logic [D-1:0]  r_surv     [NSTATES];
  logic [MW-1:0] w_pm_nxt   [NSTATES];
  logic [D-1:0]  w_surv_nxt [NSTATES];
  logic          r_dout;

  // State ns = {u, prev[5:1]}, so its two predecessors are {ns[4:0],0} and
  // {ns[4:0],1}, both reached with input u = ns[5].
  for (genvar gs = 0; gs < NSTATES; gs++) begin : g_acs
    localparam logic [5:0] NS = 6'(gs);
    localparam logic [5:0] P0 = {NS[4:0], 1'b0};
    localparam logic [5:0] P1 = {NS[4:0], 1'b1};
    localparam logic       U  = NS[5];

    logic [1:0]    w_bm0;
    logic [1:0]    w_bm1;
    logic [MW-1:0] w_m0;
    logic [MW-1:0] w_m1;
    logic [MW-1:0] w_diff;
    logic          w_sel1;

    assign w_bm0 = hamming2(d_in, exp_sym(P0, U));
    assign w_bm1 = hamming2(d_in, exp_sym(P1, U));
    assign w_m0  = r_pm[P0] + {{(MW-2){1'b0}}, w_bm0};
    assign w_m1  = r_pm[P1] + {{(MW-2){1'b0}}, w_bm1};

    // Metrics wrap freely; their spread stays far below 2^(MW-1), so the
    // sign of the modular difference orders them. Ties keep P0.
    assign w_diff = w_m0 - w_m1;
    assign w_sel1 = !w_diff[MW-1] && (w_diff != '0);

    assign w_pm_nxt[gs]   = w_sel1 ? w_m1 : w_m0;
    assign w_surv_nxt[gs] = w_sel1 ? {r_surv[P1][D-2:0], U}
                                   : {r_surv[P0][D-2:0], U};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTATES; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
        r_surv[i] <= '0;
      end
      r_dout <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < NSTATES; i++) begin
        r_pm[i]   <= w_pm_nxt[i];
        r_surv[i] <= w_surv_nxt[i];
      end
      // Oldest bit of the freshly updated state-0 survivor: bit n-47.
      r_dout <= w_surv_nxt[0][D-1];
    end
  end

  assign d_out = r_dout;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder
// Loopback bench: encoder -> optional symbol corruption -> viterbi_decoder.
// Reference: code symbols are computed directly as the mod-2 convolution of
// the input bit history with the generator taps; the decoder output is
// expected to equal the input stream delayed by 47 enabled symbols.
module tb_viterbi_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_en;
  logic       enc_in;
  logic       enc_valid;
  logic [1:0] enc_out;
  logic [1:0] err;
  logic [1:0] dec_in;
  logic       dec_out;

  int total = 0;
  int bad   = 0;

  // Reference-model state
  logic in_bits[$];
  int   dec_count;
  logic last_exp;
  bit   inject;

  logic [6:0] g1_taps = 7'o171;
  logic [6:0] g0_taps = 7'o133;
  logic [1:0] imp_tab [8] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00};

  always #5 clk = ~clk;

  assign dec_in = enc_out ^ err;

  encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_en),
    .d_in     (enc_in),
    .valid_o  (enc_valid),
    .d_out    (enc_out)
  );

  viterbi_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .enable (dec_in_valid()),
    .d_in   (dec_in),
    .d_out  (dec_out)
  );

  function automatic logic dec_in_valid();
    return enc_valid;
  endfunction

  // c = sum over j of g[6-j] * u[k-j] (mod 2); bits before the stream are 0.
  function automatic logic [1:0] model_sym(input int k);
    logic c1, c0;
    c1 = 1'b0;
    c0 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (k - j >= 0) begin
        c1 ^= g1_taps[6-j] & in_bits[k-j];
        c0 ^= g0_taps[6-j] & in_bits[k-j];
      end
    end
    return {c1, c0};
  endfunction

  task automatic clear_model();
    in_bits.delete();
    dec_count = 0;
    last_exp  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    enc_en = 1'b0;
    enc_in = 1'b0;
    err    = 2'b00;
    #1;
    total++;
    assert (dec_out === 1'b0) else begin bad++; $error("FAIL rst_dout got=%b exp=0", dec_out); end
    total++;
    assert (enc_valid === 1'b0) else begin bad++; $error("FAIL rst_valid got=%b exp=0", enc_valid); end
    total++;
    assert (enc_out === 2'b00) else begin bad++; $error("FAIL rst_encout got=%b exp=00", enc_out); end
    @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  // One clock: called at a negedge, returns at the following negedge after
  // checking encoder and decoder outputs against the model.
  task automatic step(input logic en, input logic b);
    logic       dec_fire;
    logic [1:0] exp_sym_v;
    int         m;
    enc_en   = en;
    enc_in   = b;
    m        = dec_count % 32;
    err      = (inject && enc_valid && (m == 10 || m == 11)) ? 2'b11 : 2'b00;
    dec_fire = enc_valid;
    @(posedge clk);
    @(negedge clk);
    if (en) begin
      in_bits.push_back(b);
      exp_sym_v = model_sym(in_bits.size() - 1);
    end else begin
      exp_sym_v = 2'b00;
    end
    total++;
    assert (enc_valid === en) else begin bad++; $error("FAIL enc_valid got=%b exp=%b", enc_valid, en); end
    total++;
    assert (enc_out === exp_sym_v) else begin bad++; $error("FAIL enc_sym k=%0d got=%b exp=%b", in_bits.size() - 1, enc_out, exp_sym_v); end
    if (dec_fire) begin
      last_exp = (dec_count >= 47) ? in_bits[dec_count - 47] : 1'b0;
      dec_count++;
    end
    total++;
    assert (dec_out === last_exp) else begin bad++; $error("FAIL dec_out n=%0d got=%b exp=%b", dec_count - 1, dec_out, last_exp); end
  endtask

  task automatic run_stream(input int nbits, input bit gapped, input int pattern);
    int   sent;
    logic en, b;
    sent = 0;
    while (sent < nbits + 48) begin
      en = gapped ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sent >= nbits)     b = 1'b0;
      else if (pattern == 0) b = 1'($urandom_range(0, 1));
      else if (pattern == 1) b = 1'b0;
      else                   b = 1'b1;
      step(en, b);
      if (en) sent++;
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    total++;
    assert (dec_count === nbits + 48) else begin bad++; $error("FAIL sym_count got=%0d exp=%0d", dec_count, nbits + 48); end
  endtask

  initial begin
    rst    = 1'b0;
    enc_en = 1'b0;
    enc_in = 1'b0;
    err    = 2'b00;
    inject = 1'b0;
    clear_model();

    // Reset values
    do_reset();

    // Encoder impulse response
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 0) ? 1'b1 : 1'b0);
      total++;
      assert (enc_out === imp_tab[(i < 8) ? i : 7])
        else begin bad++; $error("FAIL impulse i=%0d got=%b exp=%b", i, enc_out, imp_tab[(i < 8) ? i : 7]); end
    end

    // Clean loopback, 256 random bits
    do_reset();
    run_stream(256, 1'b0, 0);

    // Symbols 10 and 11 of every 32 inverted
    do_reset();
    inject = 1'b1;
    run_stream(256, 1'b0, 0);
    inject = 1'b0;

    // Random enable gaps
    do_reset();
    run_stream(200, 1'b1, 0);

    // All zeros, then all ones
    do_reset();
    run_stream(100, 1'b0, 1);
    do_reset();
    run_stream(100, 1'b0, 2);

    // Asynchronous reset in the middle of a stream, then restart
    do_reset();
    for (int i = 0; i < 80; i++) step(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    total++;
    assert (dec_out === 1'b0) else begin bad++; $error("FAIL midrst_dout got=%b exp=0", dec_out); end
    total++;
    assert (enc_valid === 1'b0) else begin bad++; $error("FAIL midrst_valid got=%b exp=0", enc_valid); end
    @(negedge clk);
    rst    = 1'b1;
    enc_en = 1'b0;
    clear_model();
    run_stream(120, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  high = d_in carries a valid code symbol this cycle.
REQ-005 d_in  input  2  received symbol {c1,c0}, hard decision.
REQ-006 d_out  output  1  registered decoded information bit.

Function
REQ-007 Code: rate 1/2, constraint length K=7, generators g1=171 octal (d_in[1]), g0=133 octal (d_in[0]); MSB tap = newest bit.
REQ-008 Trellis: 64 states, state = last 6 input bits, newest in bit 5; new state = {u, state[5:1]}.
REQ-009 Branch metric: Hamming distance (0..2) between d_in and expected symbol of the branch.
REQ-010 Add-compare-select on every enable cycle for all 64 states; on a tie the predecessor with the lower state index wins.
REQ-011 Path metrics: 8-bit unsigned, modular; compare via sign of the 8-bit difference; no explicit normalization.
REQ-012 Survivors: register exchange, depth D=48; each state's survivor is copied from the selected predecessor and shifted, with the new input bit appended.
REQ-013 Output: on each enable cycle d_out <= oldest survivor bit of state 0, i.e. after the n-th enabled edge (n from 0) d_out = decoded bit n-47; latency = 48 enabled symbols.
REQ-014 enable low: metrics, survivors and d_out hold.
REQ-015 No trellis termination; the stream is continuous.
REQ-016 Correction: with a clean start, symbol pairs inverted at 2 consecutive positions of every 32 symbols SHALL cause zero decoded errors.

Reset
REQ-017 Reset: metric[0]=0, all other metrics=64.
REQ-018 Reset: all survivors 0; d_out=0.
REQ-019 Reset mid-stream: all state returns to reset values immediately; decoding restarts at the next enable.

Structure
REQ-020 Package viterbi_pkg SHALL hold K, NSTATES=64, D=48, metric width 8, both generator constants, and a parity/expected-symbol function.
REQ-021 Sub-module encoder (same clk, rst; ports enable_i 1, d_in 1, valid_o 1, d_out 2) is the matching convolutional encoder.
REQ-022 encoder: registered outputs; when enable_i high: d_out <= {parity(g1 & {d_in,s}), parity(g0 & {d_in,s})}, valid_o <= 1, s <= {d_in, s[5:1]}.
REQ-023 encoder: when enable_i low: valid_o <= 0, d_out <= 00, s holds; reset clears s, d_out and valid_o.
REQ-024 ACS SHALL be written as a generate/for loop over states; no per-state hand instantiation.

Verification
REQ-025 Reset: after rst low, d_out=0, encoder valid_o=0, d_out=00.
REQ-026 Encoder impulse: inputs 1 then zeros -> d_out sequence 11,10,11,11,00,01,11, then 00.
REQ-027 Clean loopback: 256 random bits through encoder -> decoder -> d_out equals input delayed 48 enabled symbols, 0 errors.
REQ-028 Error injection: invert both bits of symbols 10 and 11 of every 32 symbols, 256 bits -> 0 decoded errors.
REQ-029 Gapped enable: random enable deassertions -> output unchanged relative to the enabled symbol stream; d_out holds during gaps.
REQ-030 All-zeros input -> d_out stays 0; all-ones input -> d_out 1 from decoded bit 0 onward, visible after 48 enabled symbols.
